cache_ctrl_sa: RTL and testbench

Parametrised set-associative, write-through, no-write-allocate cache controller that sits between the CPU load/store port and main memory. It generalises the fixed direct-mapped, fixed-latency cache to configurable sets, ways and block length. Replacement is per-set round-robin. Main memory is reached through a req/ready handshake, so memory latency is arbitrary. The CPU holds its request while `stall` is high.

---
 rtl/cache_ctrl_sa.sv | 178 +++++++++++++++++
 tb/tb_cache_ctrl_sa.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_sa.sv
// Set-associative, write-through, no-write-allocate cache controller with
// per-set round-robin replacement and a req/ready main-memory port.
module cache_ctrl_sa #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 64,
   parameter int WAYS   = 2,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              reset_neg,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_en,
   input  logic              read_en,
   output logic              stall,
   output logic [DATA_W-1:0] read_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, REFILL, DONE} state_t;
   state_t state, state_nxt;

   logic              valid [SETS][WAYS];
   logic [TAG_W-1:0]  tags  [SETS][WAYS];
   logic [DATA_W-1:0] data  [SETS][WAYS][WORDS];
   logic [WAY_W-1:0]  rr    [SETS];

   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic              lat_rd;
   logic [WAY_W-1:0]  victim;
   logic              victim_rr;
   logic [OFF_W-1:0]  cnt;

   logic [OFF_W-1:0]  off, lat_off;
   logic [IDX_W-1:0]  idx, lat_idx;
   logic [TAG_W-1:0]  tag, lat_tag;

   assign off     = address[OFF_W-1:0];
   assign idx     = address[OFF_W +: IDX_W];
   assign tag     = address[ADDR_W-1 -: TAG_W];
   assign lat_off = lat_addr[OFF_W-1:0];
   assign lat_idx = lat_addr[OFF_W +: IDX_W];
   assign lat_tag = lat_addr[ADDR_W-1 -: TAG_W];

   logic             hit, free;
   logic [WAY_W-1:0] hit_way, free_way, victim_sel, rr_next;
   logic             rd_miss, wr_hit, fill, last_word;

   // Descending scan leaves the lowest matching / lowest invalid way selected
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[idx][w] && (tags[idx][w] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[idx][w]) begin
            free     = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   assign victim_sel = free ? free_way : rr[idx];
   assign rr_next    = (rr[lat_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[lat_idx] + 1'b1;
   assign rd_miss    = (state == IDLE) && !write_en && read_en && !hit;
   assign wr_hit     = (state == IDLE) && write_en && hit;
   assign fill       = (state == REFILL) && mem_ready;
   assign last_word  = (cnt == OFF_W'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (!reset_neg) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (write_en)              state_nxt = WRITE;
            else if (read_en && !hit)  state_nxt = REFILL;
         end
         WRITE:   if (mem_ready) state_nxt = DONE;
         REFILL:  if (mem_ready && last_word) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held so an abort drops mem_req at once
   always_comb begin
      stall     = 1'b0;
      read_data = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = lat_data;
      if (reset_neg) begin
         case (state)
            IDLE: begin
               stall = write_en | (read_en & ~hit);
               if (read_en && !write_en && hit) read_data = data[idx][hit_way][off];
            end
            WRITE: begin
               stall    = 1'b1;
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               mem_addr = lat_addr;
            end
            REFILL: begin
               stall    = 1'b1;
               mem_req  = 1'b1;
               mem_addr = {lat_tag, lat_idx, cnt};
            end
            DONE: begin
               if (lat_rd) read_data = data[lat_idx][victim][lat_off];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_neg) begin
         for (int s = 0; s < SETS; s++) begin
            rr[s] <= '0;
            for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
         end
         cnt <= '0;
      end else begin
         if (rd_miss) begin
            valid[idx][victim_sel] <= 1'b0;
            cnt                    <= '0;
         end
         if (fill) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
               valid[lat_idx][victim] <= 1'b1;
               if (victim_rr) rr[lat_idx] <= rr_next;
            end
         end
      end
   end

   // Line storage and request latches carry no reset; valid bits guard them
   always_ff @(posedge clk) begin
      if ((state == IDLE) && (write_en || read_en)) begin
         lat_addr <= address;
         lat_data <= write_data;
         lat_rd   <= !write_en;
      end
      if (rd_miss) begin
         victim    <= victim_sel;
         victim_rr <= !free;
      end
      if (reset_neg) begin
         if (wr_hit) data[idx][hit_way][off] <= write_data;
         if (fill) begin
            data[lat_idx][victim][cnt] <= mem_rdata;
            if (last_word) tags[lat_idx][victim] <= lat_tag;
         end
      end
   end
endmodule

// File: tb/tb_cache_ctrl_sa.sv
// Randomized and directed bench for cache_ctrl_sa against a behavioural
// cache/memory model with a latency-configurable memory responder.
module tb_cache_ctrl_sa;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SETS   = 64;
   localparam int WAYS   = 2;
   localparam int WORDS  = 4;
   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

   logic              clk = 1'b0;
   logic              reset_neg;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic              write_en;
   logic              read_en;
   logic              stall;
   logic [DATA_W-1:0] read_data;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   cache_ctrl_sa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
      .clk(clk), .reset_neg(reset_neg), .address(address), .write_data(write_data),
      .write_en(write_en), .read_en(read_en), .stall(stall), .read_data(read_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } txn_t;
   txn_t        txn_q[$];
   logic [31:0] bmem    [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          cur_lat = 0;
   int          wcnt = 0;
   int          n_vec = 0;
   int          n_err = 0;

   bit              mval [SETS][WAYS];
   logic [TAG_W-1:0] mtag [SETS][WAYS];
   int              mrr  [SETS];

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      int s = int'(a[OFF_W +: IDX_W]);
      for (int w = 0; w < WAYS; w++)
         if (mval[s][w] && mtag[s][w] == a[ADDR_W-1:OFF_W+IDX_W]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_reset();
      for (int s = 0; s < SETS; s++) begin
         mrr[s] = 0;
         for (int w = 0; w < WAYS; w++) mval[s][w] = 1'b0;
      end
   endtask

   // Memory: cur_lat wait cycles then one ready cycle per transaction; ready is random noise when idle
   always @(negedge clk) begin
      if (mem_req) begin
         if (wcnt >= cur_lat) begin
            mem_ready = 1'b1;
            wcnt = 0;
            txn_q.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) bmem[mem_addr] = mem_wdata;
            mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : dflt(mem_addr);
         end else begin
            mem_ready = 1'b0;
            wcnt++;
            mem_rdata = $urandom;
         end
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
         wcnt = 0;
         mem_rdata = $urandom;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Entered just after a rising edge with the DUT idle; returns just after the edge ending the request
   task automatic op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                     input int lat, output int scyc, output logic [31:0] rd);
      int s, v, c, exp_c;
      bit hit, used_rr, tmo;
      logic [31:0] exp_rd;
      s = int'(a[OFF_W +: IDX_W]);
      hit = m_hit(a);
      used_rr = 1'b1;
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!mval[s][w]) begin used_rr = 1'b0; v = w; end
      if (used_rr) v = mrr[s];
      if (we)       exp_c = lat + 2;
      else if (hit) exp_c = 0;
      else          exp_c = 1 + WORDS * (lat + 1);
      exp_rd = we ? 32'd0 : ref_rd(a);
      cur_lat = lat;
      txn_q.delete();
      write_en = we; read_en = re; address = a; write_data = d;
      c = 0; tmo = 1'b0;
      forever begin
         @(negedge clk);
         if (!stall) break;
         chk("stall_read_data", 64'(read_data), 64'd0);
         chk("stall_mem_req", 64'(mem_req), 64'(c != 0));
         if (c != 0) chk("stall_mem_we", 64'(mem_we), 64'(we));
         c++;
         if (c > 200) begin tmo = 1'b1; break; end
         @(posedge clk); #1;
      end
      scyc = c;
      rd = read_data;
      chk("op_timeout", 64'(tmo), 64'd0);
      if (!tmo) begin
         chk("done_mem_req", 64'(mem_req), 64'd0);
         chk("read_data", 64'(rd), 64'(exp_rd));
         chk("stall_cycles", 64'(c), 64'(exp_c));
         if (we) begin
            chk("wr_txn_count", 64'(txn_q.size()), 64'd1);
            if (txn_q.size() == 1) begin
               chk("wr_txn_we", 64'(txn_q[0].we), 64'd1);
               chk("wr_txn_addr", 64'(txn_q[0].addr), 64'(a));
               chk("wr_txn_data", 64'(txn_q[0].data), 64'(d));
            end
         end else if (!hit) begin
            chk("refill_txn_count", 64'(txn_q.size()), 64'(WORDS));
            for (int i = 0; i < txn_q.size() && i < WORDS; i++) begin
               chk("refill_txn_we", 64'(txn_q[i].we), 64'd0);
               chk("refill_txn_addr", 64'(txn_q[i].addr), 64'({a[ADDR_W-1:OFF_W], OFF_W'(i)}));
            end
         end else begin
            chk("hit_txn_count", 64'(txn_q.size()), 64'd0);
         end
      end
      if (we) ref_mem[a] = d;
      else if (!hit) begin
         mval[s][v] = 1'b1;
         mtag[s][v] = a[ADDR_W-1:OFF_W+IDX_W];
         if (used_rr) mrr[s] = (mrr[s] + 1) % WAYS;
      end
      @(posedge clk); #1;
      write_en = 1'b0; read_en = 1'b0;
   endtask

   task automatic reset_mid_refill(input logic [31:0] a);
      int c = 0;
      cur_lat = 3;
      txn_q.delete();
      write_en = 1'b0; read_en = 1'b1; address = a;
      while (txn_q.size() < 2 && c < 200) begin
         @(posedge clk);
         c++;
      end
      chk("mid_refill_reached", 64'(c < 200), 64'd1);
      #1;
      reset_neg = 1'b0;
      read_en = 1'b0;
      @(negedge clk);
      chk("abort_mem_req", 64'(mem_req), 64'd0);
      chk("abort_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_mem_req_next", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      reset_neg = 1'b1;
      m_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      logic [31:0] rd, a, d, tg, ix;
      bit we, re;
      int lat;
      reset_neg = 1'b0; write_en = 1'b1; read_en = 1'b0; address = 128; write_data = 32'hDEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         chk("reset_stall", 64'(stall), 64'd0);
         chk("reset_mem_req", 64'(mem_req), 64'd0);
         chk("reset_mem_we", 64'(mem_we), 64'd0);
         chk("reset_read_data", 64'(read_data), 64'd0);
      end
      @(posedge clk); #1;
      reset_neg = 1'b1; write_en = 1'b0;
      m_reset();

      op(1'b1, 1'b0, 128, 1, 3, sc, rd);
      chk("tp_write_cycles", 64'(sc), 64'd5);
      op(1'b1, 1'b0, 129, 2, 3, sc, rd);
      op(1'b1, 1'b0, 130, 3, 3, sc, rd);
      op(1'b1, 1'b0, 131, 4, 3, sc, rd);
      op(1'b0, 1'b1, 128, 0, 3, sc, rd);
      chk("tp_refill_cycles", 64'(sc), 64'd17);
      chk("tp_refill_data", 64'(rd), 64'd1);
      for (int i = 1; i < 4; i++) begin
         op(1'b0, 1'b1, 32'(128 + i), 0, 3, sc, rd);
         chk("tp_hit_cycles", 64'(sc), 64'd0);
         chk("tp_hit_data", 64'(rd), 64'(i + 1));
      end
      op(1'b1, 1'b0, 130, 15, 3, sc, rd);
      op(1'b0, 1'b1, 130, 0, 3, sc, rd);
      chk("tp_write_hit_data", 64'(rd), 64'd15);

      op(1'b0, 1'b1, 128, 0, 3, sc, rd);
      chk("tp_conf_128_hit", 64'(sc), 64'd0);
      op(1'b0, 1'b1, 384, 0, 3, sc, rd);
      chk("tp_conf_384_miss", 64'(sc), 64'd17);
      op(1'b0, 1'b1, 640, 0, 3, sc, rd);
      chk("tp_conf_640_miss", 64'(sc), 64'd17);
      op(1'b0, 1'b1, 384, 0, 3, sc, rd);
      chk("tp_conf_384_hit", 64'(sc), 64'd0);
      op(1'b0, 1'b1, 128, 0, 3, sc, rd);
      chk("tp_conf_128_miss", 64'(sc), 64'd17);
      chk("tp_conf_128_data", 64'(rd), 64'd1);

      op(1'b0, 1'b1, 384, 0, 3, sc, rd);
      op(1'b0, 1'b1, 640, 0, 3, sc, rd);
      reset_mid_refill(128);
      op(1'b0, 1'b1, 128, 0, 3, sc, rd);
      chk("tp_post_abort_miss", 64'(sc), 64'd17);
      chk("tp_post_abort_data", 64'(rd), 64'd1);

      for (int n = 0; n < 400; n++) begin
         tg = 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) tg = tg | 32'h0080_0000;
         ix = 32'($urandom_range(0, 3));
         if (ix == 3) ix = 32;
         a = (tg << (OFF_W + IDX_W)) | (ix << OFF_W) | 32'($urandom_range(0, WORDS - 1));
         we = ($urandom_range(0, 9) < 4);
         re = we ? 1'($urandom_range(0, 1)) : 1'b1;
         d = $urandom;
         lat = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
         end
         op(we, re, a, d, lat, sc, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
